// File: rtl/cart_ram_uploader_if.sv
// Host-side ioctl upload bus between hps_io and cart_ram_uploader.
//   ioctl_upload : session active (host -> uploader)
//   ioctl_rd     : one-cycle pulse, host consumed ioctl_din for ioctl_addr
//   ioctl_addr   : host byte address of the byte just consumed
//   ioctl_din    : byte presented to the host (uploader -> host)
//   ioctl_wait   : ioctl_din not yet valid (uploader -> host)
interface cart_ram_uploader_if;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr,
    input  ioctl_din, ioctl_wait
  );

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr,
    output ioctl_din, ioctl_wait
  );
endinterface

// File: rtl/cart_ram_uploader.sv
// Read-back engine for the HPS ioctl upload path (cart RAM save, ROM dump).
// Reads the spare port of the cart dual-port RAM, presents bytes on ioctl_din
// and holds the host off with ioctl_wait until each byte is valid. The byte
// after the one the host just consumed is always prefetched.
// Ports:
//   clk_sys     : system clock, rising edge
//   reset       : synchronous, active-high
//   ioctl       : host upload bus (slave side)
//   img_size    : number of valid bytes, sampled at session start
//   mem_addr    : RAM read address
//   mem_rd      : one-cycle RAM read strobe
//   mem_q       : RAM read data, valid RD_LAT clocks after mem_rd
//   busy        : session active
//   byte_count  : bytes served in the current or last session (saturating)
//   upload_done : one-cycle pulse when the host ends the session
module cart_ram_uploader #(
  parameter int          AW     = 15,
  parameter int          RD_LAT = 1,
  parameter logic [7:0]  FILL   = 8'hFF
) (
  input  logic                clk_sys,
  input  logic                reset,
  cart_ram_uploader_if.slave  ioctl,
  input  logic [AW:0]         img_size,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_rd,
  input  logic [7:0]          mem_q,
  output logic                busy,
  output logic [AW:0]         byte_count,
  output logic                upload_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] LAT   = 2'd2;
  localparam logic [1:0] READY = 2'd3;

  localparam logic [1:0]  LAT_INIT = 2'(RD_LAT);
  localparam logic [25:0] DEPTH    = 26'(1) << AW;

  logic [1:0]  state;
  logic [1:0]  lat_cnt;
  logic [AW:0] size_q;
  // One bit wider than ioctl_addr so that all-ones + 1 cannot wrap back
  // into the valid range.
  logic [25:0] tgt;
  logic        upload_p1;
  logic        rise, fall, hit;

  function automatic logic tgt_in_range(input logic [25:0] t, input logic [AW:0] sz);
    return (t < DEPTH) && (t[AW:0] < sz);
  endfunction

  function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
    return (&v) ? v : v + (AW+1)'(1);
  endfunction

  assign rise = ioctl.ioctl_upload & ~upload_p1;
  assign fall = ~ioctl.ioctl_upload & upload_p1;
  assign hit  = tgt_in_range(tgt, size_q);

  // The read strobe is decoded from ISSUE so the RAM samples the address on
  // the edge that leaves ISSUE; the capture in LAT then lands exactly
  // RD_LAT+1 cycles after ISSUE was entered.
  assign mem_rd   = (state == ISSUE) && hit;
  assign mem_addr = tgt[AW-1:0];

  // Upload edge detector runs through reset so a session held high across
  // reset is not mistaken for a new one.
  always_ff @(posedge clk_sys) begin
    upload_p1 <= ioctl.ioctl_upload;
  end

  always_ff @(posedge clk_sys) begin
    size_q <= size_q;
    if (state == IDLE && rise) begin
      size_q <= img_size;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state            <= IDLE;
      lat_cnt          <= 2'd0;
      tgt              <= 26'd0;
      ioctl.ioctl_din  <= 8'd0;
      ioctl.ioctl_wait <= 1'b0;
      busy             <= 1'b0;
      byte_count       <= '0;
      upload_done      <= 1'b0;
    end else begin
      upload_done <= 1'b0;
      if (state != IDLE && fall) begin
        // A read coinciding with the end of session still counts, but no
        // further fetch is started.
        if (state == READY && ioctl.ioctl_rd) begin
          byte_count <= sat_inc(byte_count);
        end
        state            <= IDLE;
        ioctl.ioctl_wait <= 1'b0;
        busy             <= 1'b0;
        upload_done      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              byte_count       <= '0;
              tgt              <= 26'd0;
              busy             <= 1'b1;
              ioctl.ioctl_wait <= 1'b1;
              state            <= ISSUE;
            end
          end
          ISSUE: begin
            if (hit) begin
              lat_cnt <= LAT_INIT;
              state   <= LAT;
            end else begin
              ioctl.ioctl_din  <= FILL;
              ioctl.ioctl_wait <= 1'b0;
              state            <= READY;
            end
          end
          LAT: begin
            if (lat_cnt <= 2'd1) begin
              ioctl.ioctl_din  <= mem_q;
              ioctl.ioctl_wait <= 1'b0;
              state            <= READY;
            end else begin
              lat_cnt <= lat_cnt - 2'd1;
            end
          end
          READY: begin
            // Reads arriving in ISSUE/LAT never reach here and are dropped.
            if (ioctl.ioctl_rd) begin
              byte_count       <= sat_inc(byte_count);
              tgt              <= 26'(ioctl.ioctl_addr) + 26'd1;
              ioctl.ioctl_wait <= 1'b1;
              state            <= ISSUE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cart_ram_uploader.sv
// Bench for cart_ram_uploader: two instances (RD_LAT=1 and RD_LAT=3) share
// the host stimulus, each with its own RAM latency model and shared contents.
module tb_cart_ram_uploader;
  localparam int AW = 15;
  localparam int DEPTH = 1 << AW;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset;
  logic        upload, rd;
  logic [24:0] addr;
  logic [AW:0] img_size;

  cart_ram_uploader_if if1();
  cart_ram_uploader_if if3();

  assign if1.ioctl_upload = upload;
  assign if1.ioctl_rd     = rd;
  assign if1.ioctl_addr   = addr;
  assign if3.ioctl_upload = upload;
  assign if3.ioctl_rd     = rd;
  assign if3.ioctl_addr   = addr;

  logic [AW-1:0] m1_addr, m3_addr;
  logic          m1_rd, m3_rd;
  logic [7:0]    q1, q3, p0, p1;
  logic          busy1, busy3, done1, done3;
  logic [AW:0]   cnt1, cnt3;

  cart_ram_uploader #(.AW(AW), .RD_LAT(1), .FILL(8'hFF)) u1 (
    .clk_sys(clk_sys), .reset(reset), .ioctl(if1), .img_size(img_size),
    .mem_addr(m1_addr), .mem_rd(m1_rd), .mem_q(q1), .busy(busy1),
    .byte_count(cnt1), .upload_done(done1)
  );

  cart_ram_uploader #(.AW(AW), .RD_LAT(3), .FILL(8'hFF)) u3 (
    .clk_sys(clk_sys), .reset(reset), .ioctl(if3), .img_size(img_size),
    .mem_addr(m3_addr), .mem_rd(m3_rd), .mem_q(q3), .busy(busy3),
    .byte_count(cnt3), .upload_done(done3)
  );

  // RAM models: data valid RD_LAT clocks after the edge that samples mem_rd.
  logic [7:0] ram [0:DEPTH-1];
  int nrd1 = 0, nrd3 = 0;
  logic [AW-1:0] la1, la3;
  always @(posedge clk_sys) begin
    if (m1_rd) begin q1 <= ram[m1_addr]; nrd1 <= nrd1 + 1; la1 <= m1_addr; end
    if (m3_rd) begin p0 <= ram[m3_addr]; nrd3 <= nrd3 + 1; la3 <= m3_addr; end
    p1 <= p0;
    q3 <= p1;
  end

  int total = 0, bad = 0;
  int w1, w3;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk2(input string nm, input int a1, input int a3, input int exp);
    chk({nm, "_l1"}, a1, exp);
    chk({nm, "_l3"}, a3, exp);
  endtask

  // Counts negedges with ioctl_wait high per instance until both are low.
  task automatic wait_ready(output int c1, output int c3);
    bit ok = 1'b0;
    c1 = 0;
    c3 = 0;
    for (int i = 0; i < 40; i++) begin
      if (!if1.ioctl_wait && !if3.ioctl_wait) begin
        ok = 1'b1;
        break;
      end
      if (if1.ioctl_wait) c1++;
      if (if3.ioctl_wait) c3++;
      @(negedge clk_sys);
    end
    if (!ok) chk("wait_timeout", 1, 0);
  endtask

  task automatic start_sess(input logic [AW:0] sz, output int c1, output int c3);
    @(negedge clk_sys);
    img_size = sz;
    upload = 1'b1;
    @(negedge clk_sys);
    wait_ready(c1, c3);
  endtask

  task automatic do_read(input logic [24:0] a, output int c1, output int c3);
    @(negedge clk_sys);
    rd = 1'b1;
    addr = a;
    @(negedge clk_sys);
    rd = 1'b0;
    wait_ready(c1, c3);
  endtask

  task automatic end_sess(input int exp_cnt);
    @(negedge clk_sys);
    upload = 1'b0;
    @(negedge clk_sys);
    chk2("end_busy", busy1, busy3, 0);
    chk2("end_wait", if1.ioctl_wait, if3.ioctl_wait, 0);
    chk2("end_done", done1, done3, 1);
    chk2("end_cnt", cnt1, cnt3, exp_cnt);
    @(negedge clk_sys);
    chk2("end_done_off", done1, done3, 0);
    chk2("end_cnt_hold", cnt1, cnt3, exp_cnt);
  endtask

  // Reference: byte served for target t under the latched size.
  function automatic bit in_rng(input longint t, input int sz);
    return (t < DEPTH) && (t < sz);
  endfunction

  function automatic int exp_byte(input longint t, input int sz);
    return in_rng(t, sz) ? int'(ram[t]) : 255;
  endfunction

  typedef struct {
    bit          do_rd;
    logic [24:0] a;
    logic [7:0]  din;
    int          w1;
    int          w3;
    int          cnt;
  } vec_t;

  vec_t tv[5];

  initial begin
    int base1, base3, sz, exp_f, n;
    longint t;
    logic [24:0] a;

    tv[0] = '{1'b0, 25'd0, 8'h11, 2, 4, 0};
    tv[1] = '{1'b1, 25'd0, 8'h22, 2, 4, 1};
    tv[2] = '{1'b1, 25'd1, 8'h33, 2, 4, 2};
    tv[3] = '{1'b1, 25'd2, 8'h44, 2, 4, 3};
    tv[4] = '{1'b1, 25'd3, 8'hFF, 1, 1, 4};

    for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;

    reset = 1'b1; upload = 1'b0; rd = 1'b0; addr = '0; img_size = '0;
    repeat (3) @(negedge clk_sys);
    chk2("rst_din", if1.ioctl_din, if3.ioctl_din, 0);
    chk2("rst_wait", if1.ioctl_wait, if3.ioctl_wait, 0);
    chk2("rst_busy", busy1, busy3, 0);
    chk2("rst_cnt", cnt1, cnt3, 0);
    chk2("rst_done", done1, done3, 0);
    chk2("rst_mrd", m1_rd, m3_rd, 0);
    chk2("rst_maddr", m1_addr, m3_addr, 0);
    reset = 1'b0;

    // Basic session, size 4.
    base1 = nrd1; base3 = nrd3;
    for (int i = 0; i < 5; i++) begin
      if (!tv[i].do_rd) start_sess(4, w1, w3);
      else do_read(tv[i].a, w1, w3);
      chk2("tv_din", if1.ioctl_din, if3.ioctl_din, tv[i].din);
      chk("tv_wait_l1", w1, tv[i].w1);
      chk("tv_wait_l3", w3, tv[i].w3);
      chk2("tv_cnt", cnt1, cnt3, tv[i].cnt);
      chk2("tv_busy", busy1, busy3, 1);
    end
    chk2("tv_fetches", nrd1 - base1, nrd3 - base3, 4);
    end_sess(4);

    // Empty image: all FILL, no RAM reads.
    base1 = nrd1; base3 = nrd3;
    start_sess(0, w1, w3);
    chk2("empty_din0", if1.ioctl_din, if3.ioctl_din, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      do_read(25'(i), w1, w3);
      chk2("empty_din", if1.ioctl_din, if3.ioctl_din, 8'hFF);
      chk2("empty_wait", w1, w3, 1);
    end
    chk2("empty_fetches", nrd1 - base1, nrd3 - base3, 0);
    end_sess(3);

    // Read pulse while a fetch is in flight is ignored.
    start_sess(4, w1, w3);
    @(negedge clk_sys); rd = 1'b1; addr = 25'd0;
    @(negedge clk_sys);
    chk2("viol_wait_hi", if1.ioctl_wait, if3.ioctl_wait, 1);
    rd = 1'b1; addr = 25'd7;
    @(negedge clk_sys); rd = 1'b0;
    wait_ready(w1, w3);
    chk2("viol_din", if1.ioctl_din, if3.ioctl_din, 8'h22);
    chk2("viol_cnt", cnt1, cnt3, 1);

    // Drop upload while in LAT, then restart one cycle after the fall.
    @(negedge clk_sys); rd = 1'b1; addr = 25'd1;
    @(negedge clk_sys); rd = 1'b0;
    @(negedge clk_sys); upload = 1'b0;
    @(negedge clk_sys);
    chk2("abort_wait", if1.ioctl_wait, if3.ioctl_wait, 0);
    chk2("abort_busy", busy1, busy3, 0);
    chk2("abort_done", done1, done3, 1);
    chk2("abort_cnt", cnt1, cnt3, 2);
    upload = 1'b1;
    @(negedge clk_sys);
    chk2("restart_done_off", done1, done3, 0);
    chk2("restart_cnt", cnt1, cnt3, 0);
    chk2("restart_busy", busy1, busy3, 1);
    wait_ready(w1, w3);
    chk2("restart_din", if1.ioctl_din, if3.ioctl_din, 8'h11);
    chk2("restart_addr", la1, la3, 0);

    // Read coinciding with the end of session is counted, nothing fetched.
    base1 = nrd1; base3 = nrd3;
    @(negedge clk_sys); rd = 1'b1; addr = 25'd0; upload = 1'b0;
    @(negedge clk_sys); rd = 1'b0;
    chk2("simul_cnt", cnt1, cnt3, 1);
    chk2("simul_busy", busy1, busy3, 0);
    chk2("simul_done", done1, done3, 1);
    repeat (4) @(negedge clk_sys);
    chk2("simul_fetches", nrd1 - base1, nrd3 - base3, 0);

    // Reset in the middle of a session.
    start_sess(4, w1, w3);
    do_read(25'd0, w1, w3);
    @(negedge clk_sys); reset = 1'b1;
    @(negedge clk_sys);
    chk2("mrst_din", if1.ioctl_din, if3.ioctl_din, 0);
    chk2("mrst_wait", if1.ioctl_wait, if3.ioctl_wait, 0);
    chk2("mrst_busy", busy1, busy3, 0);
    chk2("mrst_cnt", cnt1, cnt3, 0);
    chk2("mrst_done", done1, done3, 0);
    chk2("mrst_maddr", m1_addr, m3_addr, 0);
    reset = 1'b0; upload = 1'b0;
    @(negedge clk_sys);
    chk2("mrst_done2", done1, done3, 0);
    @(negedge clk_sys);
    chk2("mrst_done3", done1, done3, 0);

    // Randomized sessions against the reference model.
    for (int s = 0; s < 3; s++) begin
      sz = (s == 0) ? DEPTH : (s == 1) ? int'($urandom_range(0, 20)) : int'($urandom_range(1, 300));
      base1 = nrd1; base3 = nrd3;
      start_sess(sz[AW:0], w1, w3);
      exp_f = in_rng(0, sz) ? 1 : 0;
      chk2("rnd_din0", if1.ioctl_din, if3.ioctl_din, exp_byte(0, sz));
      chk("rnd_w0_l1", w1, in_rng(0, sz) ? 2 : 1);
      chk("rnd_w0_l3", w3, in_rng(0, sz) ? 4 : 1);
      t = 0;
      n = 0;
      for (int k = 0; k < 25; k++) begin
        case ($urandom_range(0, 9))
          6: a = 25'($urandom_range(0, sz + 3));
          7: a = 25'(1 << 20) | 25'($urandom_range(0, 5));
          8: a = 25'(DEPTH - 2 + int'($urandom_range(0, 1)));
          9: a = 25'h1FF_FFFF;
          default: a = 25'(t);
        endcase
        do_read(a, w1, w3);
        n++;
        t = longint'(a) + 1;
        chk2("rnd_din", if1.ioctl_din, if3.ioctl_din, exp_byte(t, sz));
        chk("rnd_w_l1", w1, in_rng(t, sz) ? 2 : 1);
        chk("rnd_w_l3", w3, in_rng(t, sz) ? 4 : 1);
        chk2("rnd_cnt", cnt1, cnt3, n);
        if (in_rng(t, sz)) begin
          exp_f++;
          chk2("rnd_maddr", la1, la3, int'(t));
        end
      end
      chk2("rnd_fetches", nrd1 - base1, nrd3 - base3, exp_f);
      end_sess(n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cart_ram_uploader.md
Name: cart_ram_uploader

Overview:
- Read-back engine for the HPS ioctl upload path. It is the other direction of the existing ROM/cart download writer.
- Serves host upload requests (cart RAM / SuperChip RAM save, ROM dump) by reading the cart dual-port RAM's spare port, presenting bytes on ioctl_din and throttling the host with ioctl_wait.
- Sits beside hps_io in the core top level, in the clk_sys domain.

Parameters:
- AW, 15, memory address width; memory depth is 2^AW bytes.
- RD_LAT, 1, memory read latency in clocks from mem_rd to valid mem_q; legal range 1..3.
- FILL, 8'hFF, byte returned for addresses at or beyond the latched image size.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_upload  in  1  high for the whole host upload session.
- ioctl_rd  in  1  one-cycle pulse; host has consumed ioctl_din for ioctl_addr.
- ioctl_addr  in  25  host byte address.
- ioctl_din  out  8  byte presented to the host.
- ioctl_wait  out  1  high while ioctl_din is not yet valid.
- img_size  in  AW+1  number of valid bytes; sampled at session start.
- mem_addr  out  AW  read address to the RAM port.
- mem_rd  out  1  one-cycle read strobe.
- mem_q  in  8  RAM read data.
- busy  out  1  session active.
- byte_count  out  AW+1  number of bytes served in the current or last session.
- upload_done  out  1  one-cycle pulse at session end.

Behaviour:
- Reset values: ioctl_din=0, ioctl_wait=0, mem_addr=0, mem_rd=0, busy=0, byte_count=0, upload_done=0, state=IDLE.
- States: IDLE, ISSUE, LAT, READY.
- Start of session:
  - Rising edge of ioctl_upload (registered edge detect) in IDLE: latch size_q=img_size, byte_count=0, tgt=0, busy=1, ioctl_wait=1, go to ISSUE.
  - This prefetches byte 0 before the host's first read.
- ISSUE:
  - If tgt < size_q and tgt < 2^AW: drive mem_addr=tgt[AW-1:0], pulse mem_rd for 1 cycle, load lat_cnt=RD_LAT, go to LAT.
  - Otherwise (out of range): ioctl_din=FILL, no mem_rd, go directly to READY with ioctl_wait=0.
- LAT: decrement lat_cnt each cycle. When it reaches 0, capture mem_q into ioctl_din, drop ioctl_wait, go to READY.
- In-range fetch latency: ioctl_wait falls exactly RD_LAT+1 cycles after ISSUE is entered.
- READY:
  - On ioctl_rd: byte_count+=1 (saturates at all-ones), tgt=ioctl_addr+1, ioctl_wait=1 in the next cycle, go to ISSUE.
  - The next byte is prefetched for the incremented host address.
  - If the host later reads a non-sequential address, it is the host's responsibility; the block always serves last-read-address+1.
- ioctl_rd outside READY (during ISSUE/LAT) is a protocol violation: ignored, byte_count unchanged, fetch continues.
- End of session: falling edge of ioctl_upload in any non-IDLE state:
  - Abandon any in-flight fetch; mem_rd=0, ioctl_wait=0, busy=0.
  - upload_done=1 for exactly 1 cycle; byte_count holds its value until the next session start.
  - Go to IDLE.
- Simultaneous events:
  - ioctl_rd in the same cycle as the falling edge of ioctl_upload: the read is counted, then the session ends; no new fetch is issued.
  - Rising edge of ioctl_upload one cycle after a falling edge starts a fresh session normally.
- img_size=0: every byte returns FILL; mem_rd is never asserted.
- Width rules:
  - Compare tgt against size_q as unsigned AW+1 bits.
  - Any ioctl_addr bit above AW set means out of range.
- Reset asserted mid-session: immediate return to reset values, no upload_done pulse.
- ioctl_wait is only ever high while busy=1.

Test Plan:
- AW=15, RD_LAT=1, img_size=4, RAM holds 11 22 33 44:
  - Raise upload -> mem_rd at addr 0; wait falls 2 cycles later; ioctl_din=11.
  - Four rd pulses -> bytes 22, 33, 44, FF in turn; byte_count=4.
- RD_LAT=3 -> wait high exactly 4 cycles after each rd; data correct.
- img_size=0, 3 reads -> FF each time, mem_rd never high, byte_count=3.
- rd pulse while wait=1 -> byte_count unchanged; ioctl_din still becomes the correct byte when wait falls.
- Drop upload during LAT -> wait=0 and busy=0 next cycle; upload_done high for 1 cycle; byte_count retained.
  - Re-raise upload -> byte_count=0, prefetch at addr 0.
- Assert reset mid-session -> all outputs 0 next cycle, no upload_done pulse.
